// File: rtl/uart_reg_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_cmd
//  Purpose  : Binary byte-command decoder sitting between a UART byte stream
//             and a 16x8 register file. 'W' addr data writes a register,
//             'R' addr returns the register contents as one tx byte.
//             Includes an inter-byte timeout and a saturating drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_reg_cmd #(
  parameter int DataWidth  = 8,
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int TimeoutCyc = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DataWidth-1:0]  rx_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DataWidth-1:0]  tx_data,
  output logic                  reg_we,
  output logic [IndexWidth-1:0] reg_waddr,
  output logic [DataWidth-1:0]  reg_wdata,
  output logic [IndexWidth-1:0] reg_raddr,
  input  logic [DataWidth-1:0]  reg_rdata,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int TimerWidth = $clog2(TimeoutCyc) + 1;

  localparam logic [DataWidth-1:0]  c_cmd_write  = DataWidth'(8'h57);
  localparam logic [DataWidth-1:0]  c_cmd_read   = DataWidth'(8'h52);
  localparam logic [DataWidth-1:0]  c_err_byte   = DataWidth'(8'h3F);
  localparam logic [TimerWidth-1:0] c_timer_last = TimerWidth'(TimeoutCyc - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_ADDR  = 3'd1,
    W_DATA  = 3'd2,
    R_ADDR  = 3'd3,
    R_LOAD  = 3'd4,
    ERR     = 3'd5,
    TX_WAIT = 3'd6
  } state_t;

  state_t                state_q,     state_d;
  logic [TimerWidth-1:0] timer_q,     timer_d;
  logic                  tx_valid_q,  tx_valid_d;
  logic [DataWidth-1:0]  tx_data_q,   tx_data_d;
  logic                  reg_we_q,    reg_we_d;
  logic [IndexWidth-1:0] reg_waddr_q, reg_waddr_d;
  logic [DataWidth-1:0]  reg_wdata_q, reg_wdata_d;
  logic [IndexWidth-1:0] reg_raddr_q, reg_raddr_d;
  logic [7:0]            drop_cnt_q,  drop_cnt_d;

  logic w_addr_ok;
  logic w_timed_state;
  logic w_drop_state;

  // Address byte is legal only when the bits above the register index are zero.
  assign w_addr_ok     = (rx_data[DataWidth-1:IndexWidth] == '0);
  assign w_timed_state = (state_q == W_ADDR) || (state_q == W_DATA) || (state_q == R_ADDR);
  assign w_drop_state  = (state_q == R_LOAD) || (state_q == ERR)    || (state_q == TX_WAIT);

  // Next-state, datapath updates, inter-byte timer and drop counter.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    reg_raddr_d = reg_raddr_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == c_cmd_write) begin
            state_d = W_ADDR;
          end else if (rx_data == c_cmd_read) begin
            state_d = R_ADDR;
          end else begin
            state_d = ERR;
          end
        end
      end
      W_ADDR: begin
        if (rx_valid) begin
          if (w_addr_ok) begin
            reg_waddr_d = rx_data[IndexWidth-1:0];
            state_d     = W_DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      W_DATA: begin
        if (rx_valid) begin
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
          state_d     = IDLE;
        end
      end
      R_ADDR: begin
        if (rx_valid) begin
          if (w_addr_ok) begin
            reg_raddr_d = rx_data[IndexWidth-1:0];
            state_d     = R_LOAD;
          end else begin
            state_d = ERR;
          end
        end
      end
      R_LOAD: begin
        // reg_raddr_q was set last cycle, so reg_rdata is now valid.
        tx_data_d  = reg_rdata;
        tx_valid_d = 1'b1;
        state_d    = TX_WAIT;
      end
      ERR: begin
        tx_data_d  = c_err_byte;
        tx_valid_d = 1'b1;
        state_d    = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A received byte always wins over timeout expiry in the same cycle.
    if (w_timed_state && !rx_valid) begin
      if (timer_q == c_timer_last) begin
        state_d = IDLE;
      end else begin
        timer_d = timer_q + TimerWidth'(1);
      end
    end

    // Bytes arriving while a response is pending are counted, never wrapping.
    if (rx_valid && w_drop_state && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_raddr_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_raddr_q <= reg_raddr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_raddr = reg_raddr_q;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_reg_cmd
//  Purpose  : Self-checking bench for uart_reg_cmd with a register-file model
//             and write/tx scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_cmd;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       reg_we;
  logic [3:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic [3:0] reg_raddr;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [16];
  logic [11:0] wr_q [$];
  logic [7:0]  tx_q [$];

  logic        prev_tv;
  logic        prev_hs;
  logic [7:0]  prev_td;
  logic [11:0] mon_w;
  logic [7:0]  mon_t;

  typedef struct {
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        wr;
    logic [11:0] wexp;
    logic        tx;
    logic [7:0]  texp;
  } vec_t;

  vec_t vecs [10];

  uart_reg_cmd #(
    .DataWidth (8),
    .NumRegs   (16),
    .TimeoutCyc(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .reg_we   (reg_we),
    .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata),
    .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: async read, sync write.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
  end
  always @(posedge clk) begin
    if (reg_we) mem[reg_waddr] <= reg_wdata;
  end
  assign reg_rdata = mem[reg_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every write pulse and tx handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        if (wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", reg_waddr, reg_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          chk("write", {20'd0, reg_waddr, reg_wdata}, {20'd0, mon_w});
        end
      end
      if (tx_valid && prev_tv && !prev_hs) chk("tx_stable", {24'd0, tx_data}, {24'd0, prev_td});
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx: got %0h, required no tx", tx_data);
        end else begin
          mon_t = tx_q.pop_front();
          chk("tx_byte", {24'd0, tx_data}, {24'd0, mon_t});
        end
      end
      prev_tv = tx_valid;
      prev_td = tx_data;
      prev_hs = tx_valid && tx_ready;
    end else begin
      prev_tv = 1'b0;
      prev_hs = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_idle: busy 1 after 200 cycles, required 0", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({name, "_tx_data"},  {24'd0, tx_data},  32'd0);
    chk({name, "_reg_we"},   {31'd0, reg_we},   32'd0);
    chk({name, "_waddr"},    {28'd0, reg_waddr}, 32'd0);
    chk({name, "_wdata"},    {24'd0, reg_wdata}, 32'd0);
    chk({name, "_raddr"},    {28'd0, reg_raddr}, 32'd0);
    chk({name, "_busy"},     {31'd0, busy},     32'd0);
    chk({name, "_drop"},     {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 8'h57, 8'h03, 8'hA5, 1'b1, 12'h3A5, 1'b0, 8'h00};
    vecs[1] = '{2, 8'h52, 8'h03, 8'h00, 1'b0, 12'h000, 1'b1, 8'hA5};
    vecs[2] = '{1, 8'h41, 8'h00, 8'h00, 1'b0, 12'h000, 1'b1, 8'h3F};
    vecs[3] = '{2, 8'h57, 8'h1F, 8'h00, 1'b0, 12'h000, 1'b1, 8'h3F};
    vecs[4] = '{3, 8'h57, 8'h01, 8'h22, 1'b1, 12'h122, 1'b0, 8'h00};
    vecs[5] = '{2, 8'h52, 8'h01, 8'h00, 1'b0, 12'h000, 1'b1, 8'h22};
    vecs[6] = '{2, 8'h52, 8'hF0, 8'h00, 1'b0, 12'h000, 1'b1, 8'h3F};
    vecs[7] = '{3, 8'h57, 8'h0F, 8'h5C, 1'b1, 12'hF5C, 1'b0, 8'h00};
    vecs[8] = '{2, 8'h52, 8'h0F, 8'h00, 1'b0, 12'h000, 1'b1, 8'h5C};
    vecs[9] = '{2, 8'h52, 8'h07, 8'h00, 1'b0, 12'h000, 1'b1, 8'h17};

    prev_tv  = 1'b0;
    prev_hs  = 1'b0;
    prev_td  = 8'h00;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Table-driven commands.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) wr_q.push_back(vecs[i].wexp);
      if (vecs[i].tx) tx_q.push_back(vecs[i].texp);
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      wait_idle("vec");
      chk("vec_wr_drained", wr_q.size(), 32'd0);
      chk("vec_tx_drained", tx_q.size(), 32'd0);
    end

    // Read latency: tx_valid appears two cycles after the address byte.
    tx_q.push_back(8'hA5);
    send_byte(8'h52);
    send_byte(8'h03);
    @(negedge clk);
    chk("rd_lat_n1", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    chk("rd_lat_n2", {31'd0, tx_valid}, 32'd1);
    chk("rd_lat_data", {24'd0, tx_data}, 32'hA5);
    wait_idle("rd_lat");

    // Write latency: reg_we pulses exactly once, the cycle after the data byte.
    wr_q.push_back(12'h93C);
    send_byte(8'h57);
    send_byte(8'h09);
    send_byte(8'h3C);
    @(negedge clk);
    chk("wr_lat_we", {31'd0, reg_we}, 32'd1);
    @(negedge clk);
    chk("wr_pulse_end", {31'd0, reg_we}, 32'd0);
    chk("wr_busy_low", {31'd0, busy}, 32'd0);
    wait_idle("wr_lat");

    // Backpressure: response held and stable, extra bytes dropped.
    tx_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h05);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx_valid = (i == 3 || i == 8 || i == 12);
      rx_data  = 8'h99;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", {31'd0, tx_valid}, 32'd1);
    chk("bp_data", {24'd0, tx_data}, 32'h15);
    chk("bp_drop", {24'd0, drop_cnt}, 32'd3);
    tx_q.push_back(8'h15);
    tx_ready = 1'b1;
    wait_idle("bp");
    chk("bp_tx_drained", tx_q.size(), 32'd0);

    // Slow but in-time command still writes.
    wr_q.push_back(12'h466);
    send_byte(8'h57);
    repeat (10) @(posedge clk);
    send_byte(8'h04);
    repeat (10) @(posedge clk);
    send_byte(8'h66);
    wait_idle("slow_wr");
    chk("slow_wr_drained", wr_q.size(), 32'd0);

    // Timeout: partial write abandoned, following byte treated as a new command.
    send_byte(8'h57);
    send_byte(8'h02);
    repeat (5) @(negedge clk);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    repeat (30) @(negedge clk);
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    tx_q.push_back(8'h3F);
    send_byte(8'h33);
    wait_idle("to_err");
    chk("to_tx_drained", tx_q.size(), 32'd0);

    // Reset during W_DATA: outputs clear at once, no write follows.
    send_byte(8'h57);
    send_byte(8'h06);
    chk("rst_wd_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wdata");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wd_busy", {31'd0, busy}, 32'd0);

    // Reset during TX_WAIT: pending byte lost.
    tx_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h03);
    send_byte(8'h77);
    @(negedge clk);
    chk("rst_tw_valid_pre", {31'd0, tx_valid}, 32'd1);
    chk("rst_tw_drop_pre", {24'd0, drop_cnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_txwait");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Drop counter saturates.
    send_byte(8'h52);
    send_byte(8'h00);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop", {24'd0, drop_cnt}, 32'hFF);
    chk("sat_valid", {31'd0, tx_valid}, 32'd1);
    tx_q.push_back(8'h10);
    tx_ready = 1'b1;
    wait_idle("sat");

    chk("end_wr_drained", wr_q.size(), 32'd0);
    chk("end_tx_drained", tx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
